// File: rtl/router_rr.sv
`default_nettype none
// ============================================================================
// Module   : router_rr
// Desc     : N x N serial packet router with per-output round-robin arbitration
//            and one-cycle forwarding. Define ROUTER_RR_PKT_CNT_EN to add
//            per-output completed-packet counters (o_pkt_cnt).
// Revision : 1.0
// ============================================================================
module router_rr #(
    parameter int N_PORTS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     i_frame,
    input  logic [N_PORTS-1:0]     i_valid,
    input  logic [N_PORTS-1:0]     i_data,
    output logic [N_PORTS-1:0]     o_grant,
    output logic [N_PORTS-1:0]     o_frame,
    output logic [N_PORTS-1:0]     o_valid,
`ifdef ROUTER_RR_PKT_CNT_EN
    output logic [N_PORTS*16-1:0]  o_pkt_cnt,
`endif
    output logic [N_PORTS-1:0]     o_data
);

    localparam int ADDR_W = $clog2(N_PORTS);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_addr = 3'd1;
    localparam logic [2:0] c_st_req  = 3'd2;
    localparam logic [2:0] c_st_xfer = 3'd3;
    localparam logic [2:0] c_st_drop = 3'd4;

    localparam logic [ADDR_W:0]   c_n_ports   = (ADDR_W+1)'(N_PORTS);
    localparam logic [ADDR_W-1:0] c_last_bit  = ADDR_W'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] c_last_port = ADDR_W'(N_PORTS - 1);

    // Per-input state
    logic [2:0]        r_state [N_PORTS];
    logic [ADDR_W-1:0] r_addr  [N_PORTS];
    logic [ADDR_W-1:0] r_cnt   [N_PORTS];
    logic [N_PORTS-1:0] r_grant;

    logic [ADDR_W-1:0] w_pos       [N_PORTS];
    logic [ADDR_W-1:0] w_addr_next [N_PORTS];
    logic [N_PORTS-1:0] w_addr_done;
    logic [N_PORTS-1:0] w_addr_bad;
    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_gnt_in;

    // Per-output state
    logic [N_PORTS-1:0] r_owned;
    logic [ADDR_W-1:0]  r_owner [N_PORTS];
    logic [ADDR_W-1:0]  r_ptr   [N_PORTS];
    logic [N_PORTS-1:0] r_oframe;
    logic [N_PORTS-1:0] r_ovalid;
    logic [N_PORTS-1:0] r_odata;

    logic [N_PORTS-1:0] w_win_any;
    logic [ADDR_W-1:0]  w_win_idx [N_PORTS];
    logic [ADDR_W:0]    w_sum;

`ifdef ROUTER_RR_PKT_CNT_EN
    logic [N_PORTS*16-1:0] r_pkt_cnt;
    assign o_pkt_cnt = r_pkt_cnt;
`endif

    assign o_grant = r_grant;
    assign o_frame = r_oframe;
    assign o_valid = r_ovalid;
    assign o_data  = r_odata;

    // IDLE counts as bit position 0 so the first address bit is taken on the frame rise
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            w_pos[i]       = (r_state[i] == c_st_idle) ? '0 : r_cnt[i];
            w_addr_next[i] = ((r_state[i] == c_st_idle) ? '0 : r_addr[i])
                           | (ADDR_W'(i_data[i]) << w_pos[i]);
            w_addr_done[i] = (w_pos[i] == c_last_bit);
            w_addr_bad[i]  = ({1'b0, w_addr_next[i]} >= c_n_ports);
            w_req[i]       = (r_state[i] == c_st_req) && i_frame[i];
        end
    end

    // Round-robin search from r_ptr upward, wrapping at N_PORTS
    always_comb begin
        w_win_any = '0;
        w_gnt_in  = '0;
        w_sum     = '0;
        for (int d = 0; d < N_PORTS; d++) begin
            w_win_idx[d] = '0;
            for (int k = 0; k < N_PORTS; k++) begin
                w_sum = {1'b0, r_ptr[d]} + (ADDR_W+1)'(k);
                if (w_sum >= c_n_ports) begin
                    w_sum = w_sum - c_n_ports;
                end
                if (!w_win_any[d] && w_req[w_sum[ADDR_W-1:0]]
                    && (r_addr[w_sum[ADDR_W-1:0]] == ADDR_W'(d))) begin
                    w_win_any[d] = 1'b1;
                    w_win_idx[d] = w_sum[ADDR_W-1:0];
                end
            end
            if (!r_owned[d] && w_win_any[d]) begin
                w_gnt_in[w_win_idx[d]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_state[i] <= c_st_idle;
                r_addr[i]  <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                case (r_state[i])
                    c_st_idle, c_st_addr: begin
                        if (i_frame[i]) begin
                            r_addr[i] <= w_addr_next[i];
                            if (w_addr_done[i]) begin
                                r_cnt[i] <= '0;
                                if (w_addr_bad[i]) begin
                                    r_state[i] <= c_st_drop;
                                    r_grant[i] <= 1'b1;
                                end else begin
                                    r_state[i] <= c_st_req;
                                end
                            end else begin
                                r_cnt[i]   <= w_pos[i] + ADDR_W'(1);
                                r_state[i] <= c_st_addr;
                            end
                        end else begin
                            r_cnt[i]   <= '0;
                            r_state[i] <= c_st_idle;
                        end
                    end
                    c_st_req: begin
                        if (!i_frame[i]) begin
                            r_state[i] <= c_st_idle;
                        end else if (w_gnt_in[i]) begin
                            r_state[i] <= c_st_xfer;
                            r_grant[i] <= 1'b1;
                        end
                    end
                    c_st_xfer, c_st_drop: begin
                        if (!i_frame[i]) begin
                            r_state[i] <= c_st_idle;
                            r_grant[i] <= 1'b0;
                        end
                    end
                    default: begin
                        r_state[i] <= c_st_idle;
                        r_grant[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // An owned output always has its owner in XFER; release happens on the owner's last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owned  <= '0;
            r_oframe <= '0;
            r_ovalid <= '0;
            r_odata  <= '0;
`ifdef ROUTER_RR_PKT_CNT_EN
            r_pkt_cnt <= '0;
`endif
            for (int d = 0; d < N_PORTS; d++) begin
                r_owner[d] <= '0;
                r_ptr[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < N_PORTS; d++) begin
                if (r_owned[d]) begin
                    r_oframe[d] <= i_frame[r_owner[d]];
                    r_ovalid[d] <= i_valid[r_owner[d]];
                    r_odata[d]  <= i_data[r_owner[d]];
                    if (!i_frame[r_owner[d]]) begin
                        r_owned[d] <= 1'b0;
`ifdef ROUTER_RR_PKT_CNT_EN
                        r_pkt_cnt[d*16 +: 16] <= r_pkt_cnt[d*16 +: 16] + 16'd1;
`endif
                    end
                end else begin
                    r_oframe[d] <= 1'b0;
                    r_ovalid[d] <= 1'b0;
                    r_odata[d]  <= 1'b0;
                    if (w_win_any[d]) begin
                        r_owned[d] <= 1'b1;
                        r_owner[d] <= w_win_idx[d];
                        r_ptr[d]   <= (w_win_idx[d] == c_last_port) ? '0
                                    : w_win_idx[d] + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_rr
// Desc     : Self-checking bench for router_rr (4-port and 3-port instances).
// Revision : 1.0
// ============================================================================
module tb_router_rr;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic [3:0] frame4 = '0;
    logic [3:0] valid4 = '0;
    logic [3:0] data4  = '0;
    logic [3:0] grant4, of4, ov4, od4;

    logic [2:0] frame3 = '0;
    logic [2:0] valid3 = '0;
    logic [2:0] data3  = '0;
    logic [2:0] grant3, of3, ov3, od3;

`ifdef ROUTER_RR_PKT_CNT_EN
    logic [63:0] cnt4;
    logic [47:0] cnt3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0] frame;
        logic [3:0] valid;
        logic [3:0] data;
        logic [3:0] grant;
        logic [3:0] oframe;
        logic [3:0] ovalid;
        logic [3:0] odata;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    router_rr #(.N_PORTS(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .i_frame   (frame4),
        .i_valid   (valid4),
        .i_data    (data4),
        .o_grant   (grant4),
        .o_frame   (of4),
        .o_valid   (ov4),
`ifdef ROUTER_RR_PKT_CNT_EN
        .o_pkt_cnt (cnt4),
`endif
        .o_data    (od4)
    );

    router_rr #(.N_PORTS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .i_frame   (frame3),
        .i_valid   (valid3),
        .i_data    (data3),
        .o_grant   (grant3),
        .o_frame   (of3),
        .o_valid   (ov3),
`ifdef ROUTER_RR_PKT_CNT_EN
        .o_pkt_cnt (cnt3),
`endif
        .o_data    (od3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] f, v, d, g, o_f, o_v, o_d);
        return {f, v, d, g, o_f, o_v, o_d};
    endfunction

    // Sources in mask all target output 0; winners must appear in the given order
    task automatic contend(input logic [3:0] mask, input int nw, input int e0, input int e1, input int e2);
        int exp_w [3];
        int n;
        int src;
        exp_w[0] = e0;
        exp_w[1] = e1;
        exp_w[2] = e2;
        @(negedge clk); frame4 = mask; data4 = '0; valid4 = '0;
        @(negedge clk);
        for (int w = 0; w < nw; w++) begin
            src = exp_w[w];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (grant4 == 4'b0000 && n < 20);
            check($sformatf("contend_grant%0d", w), grant4, 4'b0001 << src);
            check("contend_gap", {of4[0], ov4[0], od4[0]}, 3'b000);
            valid4[src] = 1'b1;
            data4[src]  = 1'b1;
            @(negedge clk);
            check("contend_data", {of4[0], ov4[0], od4[0]}, 3'b111);
            data4[src]  = 1'b0;
            frame4[src] = 1'b0;
            @(negedge clk);
            check("contend_last", {of4[0], ov4[0], od4[0]}, 3'b010);
            valid4[src] = 1'b0;
        end
    endtask

    task automatic route_one(input int src, input int dst, input logic [3:0] pay);
        logic [1:0] a;
        a = dst[1:0];
        @(negedge clk); frame4[src] = 1'b1; data4[src] = a[0]; valid4[src] = 1'b0;
        @(negedge clk); data4[src] = a[1];
        @(negedge clk); check("route_early", grant4, 4'b0000); data4[src] = 1'b0;
        @(negedge clk); check("route_grant", grant4, 4'b0001 << src);
        valid4[src] = 1'b1;
        data4[src]  = pay[0];
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            check("route_data", {of4[dst], ov4[dst], od4[dst]}, {2'b11, pay[b-1]});
            data4[src] = pay[b];
            if (b == 3) frame4[src] = 1'b0;
        end
        @(negedge clk);
        check("route_last", {grant4, of4[dst], ov4[dst], od4[dst]}, {4'b0000, 2'b01, pay[3]});
        valid4[src] = 1'b0;
        data4[src]  = 1'b0;
    endtask

    task automatic reset_mid();
        @(negedge clk); frame4 = 4'b1000; data4 = 4'b1000; valid4 = '0;
        @(negedge clk); data4 = '0;
        @(negedge clk);
        @(negedge clk); check("rst_grant", grant4, 4'b1000);
        valid4 = 4'b1000;
        data4  = 4'b1000;
        @(negedge clk); check("rst_xfer", {of4[1], ov4[1], od4[1]}, 3'b111);
        #1 reset = 1'b1;
        #1;
        check("rst_async4", {grant4, of4, ov4, od4}, 16'h0000);
        check("rst_async3", {grant3, of3, ov3, od3}, 12'h000);
        frame4 = '0;
        valid4 = '0;
        data4  = '0;
        @(negedge clk); reset = 1'b0;
    endtask

    // Address 3 on a 3-port router: granted, swallowed, never forwarded
    task automatic drop3();
        @(negedge clk); frame3 = 3'b001; data3 = 3'b001; valid3 = '0;
        @(negedge clk); data3 = 3'b001;
        @(negedge clk); check("drop_grant", grant3, 3'b001);
        valid3 = 3'b001;
        data3  = 3'b001;
        @(negedge clk); check("drop_quiet", {grant3, of3, ov3, od3}, {3'b001, 9'h000});
        frame3 = '0;
        data3  = '0;
        @(negedge clk); check("drop_release", {grant3, of3, ov3, od3}, 12'h000);
        valid3 = '0;
        @(negedge clk); check("drop_idle", {grant3, of3, ov3, od3}, 12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        #2;
        check("reset4", {grant4, of4, ov4, od4}, 16'h0000);
        check("reset3", {grant3, of3, ov3, od3}, 12'h000);
        @(negedge clk); reset = 1'b0;

        // Input 1 -> output 2, payload 1,0,1,1
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // Input 0 -> output 3 and input 2 -> output 1 concurrently
        tbl.push_back(mk(4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0101, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0101, 4'b0100, 4'b0101, 4'b1010, 4'b1010, 4'b1000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0010));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // Input 2 aborts after one address bit
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

        foreach (tbl[k]) begin
            @(negedge clk);
            check($sformatf("vec%0d", k), {grant4, of4, ov4, od4},
                  {tbl[k].grant, tbl[k].oframe, tbl[k].ovalid, tbl[k].odata});
            frame4 = tbl[k].frame;
            valid4 = tbl[k].valid;
            data4  = tbl[k].data;
        end

        contend(4'b1011, 3, 0, 1, 3);
        contend(4'b1011, 3, 0, 1, 3);
        contend(4'b0100, 1, 2, 0, 0);
        contend(4'b1011, 3, 3, 0, 1);

        reset_mid();
        route_one(3, 1, 4'b1011);
        route_one(0, 1, 4'b0110);
        route_one(2, 1, 4'b1100);
        drop3();

`ifdef ROUTER_RR_PKT_CNT_EN
        check("pkt_cnt4", cnt4, {16'd0, 16'd0, 16'd3, 16'd0});
        check("pkt_cnt3", {16'd0, cnt3}, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
